// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - shared types and constants for the fetch sequencer
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } fetch_state_t;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_slot.sv
// rtl/fetch_slot.sv - registered single-entry fetch-to-decode slot with load, hold and flush
module fetch_slot
    import fetch_seq_pkg::*;
#(
    parameter int N = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [N-1:0]       load_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [N-1:0]       pc
);

    // Slot register: flush only drops the valid bit, the stale payload is harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch-stage PC sequencer with imem handshake, redirects and optional FETCH_SEQ_PERF_EN counters
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int            N        = 64,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCSrc_F,
    input  logic [N-1:0]       PCBranch_F,
    input  logic               stall_D,
    output logic               imem_req,
    output logic [N-1:0]       imem_addr_F,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid_D,
    output logic [INSTR_W-1:0] instr_D,
    output logic [N-1:0]       pc_D
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        redirect_count
`endif
);

    fetch_state_t state, state_nx;
    logic [N-1:0] pc_q, pc_nx;
    logic [N-1:0] redir_tgt_q;
    logic         redir_pend_q;
    logic         pend_set, pend_clr;
    logic         slot_load, slot_flush;

    // State register and PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc_q  <= RESET_PC;
        end else begin
            state <= state_nx;
            pc_q  <= pc_nx;
        end
    end

    // Redirect that arrives while a request is still waiting for its ack; the
    // address must stay put until the memory answers, so the target is parked here.
    always_ff @(posedge clk) begin
        if (reset) begin
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= '0;
        end else if (pend_set) begin
            redir_pend_q <= 1'b1;
            redir_tgt_q  <= PCBranch_F;
        end else if (pend_clr) begin
            redir_pend_q <= 1'b0;
        end
    end

    // Next-state, next-PC and slot control decisions.
    always_comb begin
        state_nx   = state;
        pc_nx      = pc_q;
        slot_load  = 1'b0;
        slot_flush = 1'b0;
        pend_set   = 1'b0;
        pend_clr   = 1'b0;
        case (state)
            IDLE: begin
                state_nx = REQ;
                if (PCSrc_F) begin
                    pc_nx = PCBranch_F;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    pend_clr = 1'b1;
                    if (PCSrc_F) begin
                        // A fresh redirect beats any parked target.
                        pc_nx = PCBranch_F;
                    end else if (redir_pend_q) begin
                        pc_nx = redir_tgt_q;
                    end else begin
                        slot_load = 1'b1;
                        pc_nx     = pc_q + N'(PC_STEP);
                        state_nx  = FULL;
                    end
                end else if (PCSrc_F) begin
                    pend_set = 1'b1;
                end
            end
            FULL: begin
                if (PCSrc_F) begin
                    slot_flush = 1'b1;
                    pc_nx      = PCBranch_F;
                    state_nx   = REQ;
                end else if (!stall_D) begin
                    if (imem_ack) begin
                        slot_load = 1'b1;
                        pc_nx     = pc_q + N'(PC_STEP);
                    end else begin
                        // Decode took the slot but memory is slow: keep asking from REQ.
                        slot_flush = 1'b1;
                        state_nx   = REQ;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Request output: in FULL it is only raised when the slot can be replaced.
    always_comb begin
        imem_req = 1'b0;
        case (state)
            REQ:     imem_req = 1'b1;
            FULL:    imem_req = !stall_D && !PCSrc_F;
            default: imem_req = 1'b0;
        endcase
    end

    assign imem_addr_F = pc_q;

    fetch_slot #(
        .N (N)
    ) u_slot (
        .clk        (clk),
        .reset      (reset),
        .load       (slot_load),
        .flush      (slot_flush),
        .load_instr (imem_rdata),
        .load_pc    (pc_q),
        .valid      (instr_valid_D),
        .instr      (instr_D),
        .pc         (pc_D)
    );

`ifdef FETCH_SEQ_PERF_EN
    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count    <= '0;
            redirect_count <= '0;
        end else begin
            if (slot_load) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (PCSrc_F) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized and directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrc_F;
    logic [63:0] PCBranch_F;
    logic        stall_D;
    logic        imem_req;
    logic [63:0] imem_addr_F;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid_D;
    logic [31:0] instr_D;
    logic [63:0] pc_D;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] redirect_count;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: next fetch address, the slot, parked redirect targets.
    bit          m_started;
    logic [63:0] m_pc;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [63:0] m_pcd;
    logic [63:0] pend_q[$];
    int unsigned m_fetch;
    int unsigned m_redir;

    fetch_sequencer #(
        .N        (64),
        .RESET_PC (64'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .PCSrc_F       (PCSrc_F),
        .PCBranch_F    (PCBranch_F),
        .stall_D       (stall_D),
        .imem_req      (imem_req),
        .imem_addr_F   (imem_addr_F),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid_D (instr_valid_D),
        .instr_D       (instr_D),
        .pc_D          (pc_D)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .fetch_count    (fetch_count),
        .redirect_count (redirect_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    // The sequencer asks for memory whenever it is running and the slot is
    // either empty or being handed to an accepting decode stage with no redirect.
    function automatic bit model_req(input bit stall, input bit pcsrc);
        return m_started && (!m_valid || (!stall && !pcsrc));
    endfunction

    task automatic model_reset();
        m_started = 0;
        m_pc      = 64'h0;
        m_valid   = 0;
        m_instr   = '0;
        m_pcd     = '0;
        pend_q.delete();
        m_fetch   = 0;
        m_redir   = 0;
    endtask

    task automatic step(input bit rst, input bit stall, input bit pcsrc,
                        input logic [63:0] tgt, input bit ack, input bit chk);
        bit r;
        @(negedge clk);
        reset      = rst;
        stall_D    = stall;
        PCSrc_F    = pcsrc;
        PCBranch_F = tgt;
        imem_ack   = ack;
        imem_rdata = mem_word(m_pc);
        #1;
        r = model_req(stall, pcsrc);
        if (chk) begin
            check_eq("imem_req", imem_req, r);
            check_eq("imem_addr_F", imem_addr_F, m_pc);
            check_eq("instr_valid_D", instr_valid_D, m_valid);
            if (m_valid || !m_started) begin
                check_eq("instr_D", instr_D, m_instr);
                check_eq("pc_D", pc_D, m_pcd);
            end
`ifdef FETCH_SEQ_PERF_EN
            check_eq("fetch_count", fetch_count, m_fetch);
            check_eq("redirect_count", redirect_count, m_redir);
`endif
        end
        if (rst) begin
            model_reset();
        end else begin
            if (pcsrc) m_redir++;
            if (!m_started) begin
                m_started = 1;
                if (pcsrc) m_pc = tgt;
            end else if (r && ack) begin
                if (pcsrc) begin
                    m_pc = tgt;
                    pend_q.delete();
                    m_valid = 0;
                end else if (pend_q.size() > 0) begin
                    m_pc = pend_q.pop_front();
                    m_valid = 0;
                end else begin
                    m_instr = mem_word(m_pc);
                    m_pcd   = m_pc;
                    m_valid = 1;
                    m_pc    = m_pc + 64'd4;
                    m_fetch++;
                end
            end else if (r) begin
                if (m_valid) begin
                    m_valid = 0;
                end else if (pcsrc) begin
                    pend_q.delete();
                    pend_q.push_back(tgt);
                end
            end else if (pcsrc) begin
                m_valid = 0;
                m_pc    = tgt;
            end
        end
    endtask

    task automatic cyc(input bit stall, input bit pcsrc, input logic [63:0] tgt, input bit ack_ok);
        step(1'b0, stall, pcsrc, tgt, ack_ok && model_req(stall, pcsrc), 1'b1);
    endtask

    // lat < 0 acks with 50% probability; otherwise after exactly lat waiting cycles.
    task automatic run_rand(input int n, input int lat, input int stall_pct, input int redir_pct);
        int          wait_cnt;
        bit          s, p, r, a;
        logic [63:0] t;
        wait_cnt = 0;
        for (int i = 0; i < n; i++) begin
            s = ($urandom_range(99) < stall_pct);
            p = ($urandom_range(99) < redir_pct);
            t = {$urandom(), $urandom()};
            t[1:0] = 2'b00;
            r = model_req(s, p);
            if (lat < 0) a = r && ($urandom_range(1) == 1);
            else         a = r && (wait_cnt >= lat);
            if (a)      wait_cnt = 0;
            else if (r) wait_cnt++;
            step(1'b0, s, p, t, a, 1'b1);
        end
    endtask

    initial begin
        logic [63:0] held;
        reset = 1'b1; PCSrc_F = 1'b0; PCBranch_F = '0; stall_D = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        model_reset();
        step(1'b1, 0, 0, 64'h0, 0, 1'b0);
        step(1'b1, 0, 0, 64'h0, 0, 1'b1);

        // Zero-wait memory: pc_D = 0,4,8,12 from cycle 2.
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 64'h0, 1);
            if (i >= 2) check_eq("zw_pc_D", pc_D, 64'(i - 2) * 64'd4);
        end

        // Three-cycle memory latency.
        run_rand(40, 3, 0, 0);

        // Reach FULL, then stall for five cycles.
        cyc(0, 0, 64'h0, 1);
        cyc(0, 0, 64'h0, 1);
        held = m_pcd;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 64'h0, 1);
            check_eq("stall_pc_D", pc_D, held);
            check_eq("stall_req", imem_req, 0);
        end
        cyc(0, 0, 64'h0, 1);
        check_eq("stall_next_addr", imem_addr_F, held + 64'd4);

        // Redirect two cycles before a late ack.
        cyc(0, 0, 64'h0, 0);
        cyc(0, 1, 64'h100, 0);
        cyc(0, 0, 64'h0, 0);
        cyc(0, 0, 64'h0, 1);
        cyc(0, 0, 64'h0, 1);
        check_eq("late_redir_addr", imem_addr_F, 64'h100);
        check_eq("late_redir_valid", instr_valid_D, 0);
        cyc(0, 0, 64'h0, 0);
        check_eq("late_redir_pc_D", pc_D, 64'h100);

        // Redirect in FULL under stall.
        cyc(0, 0, 64'h0, 1);
        cyc(1, 1, 64'h400, 1);
        cyc(1, 0, 64'h0, 0);
        check_eq("full_redir_valid", instr_valid_D, 0);
        check_eq("full_redir_addr", imem_addr_F, 64'h400);
        check_eq("full_redir_req", imem_req, 1);

        // Back-to-back redirects while waiting.
        cyc(0, 1, 64'h200, 0);
        cyc(0, 1, 64'h300, 0);
        cyc(0, 0, 64'h0, 1);
        cyc(0, 0, 64'h0, 1);
        cyc(0, 0, 64'h0, 0);
        check_eq("b2b_pc_D", pc_D, 64'h300);

        // Fresh redirect on the ack cycle beats the parked one.
        cyc(0, 1, 64'h500, 0);
        cyc(0, 1, 64'h600, 1);
        cyc(0, 0, 64'h0, 1);
        cyc(0, 0, 64'h0, 0);
        check_eq("ack_redir_pc_D", pc_D, 64'h600);

        // PC wrap.
        cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        cyc(0, 0, 64'h0, 1);
        cyc(0, 0, 64'h0, 1);
        check_eq("wrap_pc_D", pc_D, 64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("wrap_addr", imem_addr_F, 64'h0);

        // Reset mid-request, then a stray ack in IDLE.
        cyc(0, 0, 64'h0, 0);
        step(1'b1, 0, 0, 64'h0, 1, 1'b1);
        step(1'b0, 0, 0, 64'h0, 1, 1'b1);
        check_eq("idle_req", imem_req, 0);
        cyc(0, 0, 64'h0, 0);
        check_eq("post_rst_valid", instr_valid_D, 0);
        check_eq("post_rst_addr", imem_addr_F, 64'h0);

        // Randomized traffic.
        run_rand(600, -1, 30, 10);
        run_rand(300, 2, 20, 5);
        run_rand(600, -1, 10, 3);
        run_rand(200, 0, 40, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller that sequences the program counter against an instruction memory with a request/acknowledge handshake. It supports variable memory latency, decode back-pressure and branch redirects. It owns the PC register and the single-entry fetch→decode slot, and sits between the branch-resolution logic (PCSrc_F/PCBranch_F), instruction memory and the decode stage.

## Interface
- N, 64, PC/address width
- RESET_PC, 64'h0, PC value loaded on reset
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- PCSrc_F  in  1  redirect pulse; take PCBranch_F this cycle
- PCBranch_F  in  N  redirect target
- stall_D  in  1  decode cannot accept the slot contents this cycle
- imem_req  out  1  instruction memory request
- imem_addr_F  out  N  request address (= PC register)
- imem_ack  in  1  memory returns imem_rdata this cycle; may coincide with the first request cycle
- imem_rdata  in  32  instruction word
- instr_valid_D  out  1  slot holds a valid instruction
- instr_D  out  32  slot instruction
- pc_D  out  N  address of instr_D
- fetch_count, redirect_count  out  32  only with FETCH_SEQ_PERF_EN

## Operation
- States: IDLE, REQ, FULL.
- Reset: state=IDLE, PC=RESET_PC, imem_req=0, instr_valid_D=0, instr_D=0, pc_D=0, redirect-pending=0, counters=0.
- IDLE: imem_req=0; next state REQ.
- REQ: imem_req=1, the slot is empty.
  - Ack without redirect (now or pending): capture imem_rdata/PC into the slot, PC←PC+4, go to FULL.
  - Ack with redirect: discard data, PC←target, stay in REQ.
  - No ack: stay in REQ.
- FULL: slot valid; imem_req = !stall_D && !PCSrc_F.
  - Request with ack: recapture the slot and PC←PC+4; stay in FULL.
  - Request without ack: slot drains; go to REQ.
  - No request and no redirect: hold the slot.
- Handshake: once imem_req rises, req and imem_addr_F stay constant until imem_ack. A request is never retracted, and exactly one is outstanding.
- Redirect while waiting in REQ (no ack): latch PCBranch_F into the redirect-target register and set redirect-pending. PC is not changed until ack. On ack, drop the data and load the pending target.
- Redirect on an ack cycle, or with a redirect already pending: the current PCBranch_F wins over the pending target.
- Redirect in FULL: the slot is invalidated next cycle, PC←PCBranch_F, go to REQ.
- Any redirect clears instr_valid_D next cycle, even under stall_D.
- Arithmetic: PC+4 is modulo 2^N; wrap from all-ones-minus-3 to 0 is silent.
- Reset mid-request: returns to IDLE; an ack arriving in IDLE is ignored.

## Timing
- Zero-wait memory (ack tied high): reset released at cycle 0 → IDLE at 0; request addr RESET_PC at 1; instr_valid_D=1 at 2; then one instruction per cycle.
- Latency from ack to instr_valid_D: 1 cycle (registered slot).
- Latency from PCSrc_F to a request at the target: next cycle (from FULL or REQ-with-ack), or the cycle after a late ack.
- imem_req from FULL is combinational in stall_D and PCSrc_F. All other outputs are registered.

## Configuration
- FETCH_SEQ_PERF_EN defined:
  - fetch_count increments on each slot capture.
  - redirect_count increments on each PCSrc_F cycle.
  - Both are 32-bit, wrap, and are cleared by reset.
- Not defined: the counter ports and logic are absent; behaviour is otherwise identical.

## Structure
- Package fetch_seq_pkg holds: the state enum (IDLE/REQ/FULL), INSTR_W=32, PC_STEP=4.
- Sub-module fetch_slot: registered slot (valid/instr/pc) with load, hold and flush controls.
- The top level holds the FSM, PC, redirect-pending logic and counters.

## Test plan
- Ack tied 1, stall_D=0, RESET_PC=0 → pc_D = 0,4,8,12 on consecutive cycles starting at cycle 2.
- Ack delayed 3 cycles per request → imem_addr_F stable for 4 cycles; one instruction every 4 cycles; no duplicates.
- stall_D held 5 cycles while FULL → imem_req=0, slot held (same instr_D/pc_D); on release, the next address is pc_D+4.
- PCSrc_F=1, PCBranch_F=0x100 two cycles before a late ack → fetched word dropped, next request at 0x100, no valid instruction from the old address.
- PCSrc_F in FULL under stall_D → instr_valid_D=0 next cycle; request at the target; redirect_count=1 (perf build).
- Back-to-back redirects 0x200 then 0x300 while waiting → only 0x300 is fetched. PC at 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
